booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
Iterative radix-4 Booth multiplier with a valid/ready handshake. It recodes one Booth digit per clock and accumulates into a registered product. Width is parametrised, and a per-transaction mode selects signed or unsigned operands. It serves as the area-lean, streaming-capable successor to the combinational Booth multiplier in the datapath. One multiplication is in flight at a time.

Parameters:
WIDTH, 12, operand width in bits; must be even and >= 4 (elaboration error otherwise)
N (localparam), (WIDTH+2)/2, number of Booth digits processed per operation
CW (localparam), $clog2(N), digit counter width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands and mode presented
in_ready  output  1  block can accept operands this cycle
is_signed  input  1  1: x,y two's complement; 0: x,y unsigned; sampled with operands
x  input  WIDTH  multiplicand
y  input  WIDTH  multiplier
out_valid  output  1  p holds a completed product
out_ready  input  1  consumer accepts p this cycle
p  output  2*WIDTH  product, registered
busy  output  1  high while digits are being processed

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, p=0, busy=0, in_ready=1, counter=0, internal registers=0. Reset mid-operation discards the operation; no out_valid pulse follows.
- States:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready. On accept:
    - latch X = x extended to WIDTH+2 bits, sign-extended if is_signed, else zero-extended.
    - latch Y = y extended the same way.
    - acc=0, cnt=0, go to BUSY.
  - BUSY: busy=1, in_ready=0. Each edge processes digit k=cnt:
    - group = {Y[2k+1], Y[2k], Y[2k-1]}, with Y[-1]=0.
    - 000/111 -> 0; 001/010 -> +X; 011 -> +2X; 100 -> -2X; 101/110 -> -X.
    - acc += signed(digit*X) << 2k; acc is 2*WIDTH+4 bits signed.
    - When cnt==N-1: p <= acc_next[2*WIDTH-1:0], out_valid <= 1, go to DONE. Else cnt++.
  - DONE: out_valid=1, p stable.
    - in_ready = out_ready.
    - On out_ready with no new accept: out_valid <= 0, go to IDLE.
    - On out_ready with in_valid: accept new operands in the same cycle, go to BUSY, out_valid <= 0.
    - Without out_ready: hold indefinitely. p and out_valid must not change.
- Latency: accept edge to out_valid high takes exactly N+1 edges after the accept edge. For WIDTH=12, N=7, so out_valid is first visible 8 cycles after the accept cycle. Throughput is one result per N+1 cycles with out_ready tied high.
- Inputs x, y, is_signed are ignored outside accept cycles. Changing them during BUSY has no effect.
- Results equal the exact mathematical product truncated to 2*WIDTH bits. Both modes are exact: the product always fits.
- p retains its last value after consumption until the next completion. It is not cleared.
- in_valid with in_ready=0 is not accepted. The producer must hold it, per the standard valid/ready rule.

Decomposition:
- Shared package booth_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - 3-bit Booth digit code constants.
  - function booth_digit(group) returning a signed digit in {-2..+2}.
- One combinational sub-module, booth_r4_pp_gen:
  - inputs: 3-bit group, X (WIDTH+2 bits).
  - output: partial product, WIDTH+3 bits signed.
  - reused by the future pipelined variant.

Test Plan:
1. Signed, WIDTH=12: x=-2048, y=-2048 -> p=24'h400000, out_valid 8 cycles after accept.
2. Unsigned: x=12'hFFF, y=12'hFFF -> p=24'hFFE001. The same operands signed (-1 * -1) -> p=24'h000001.
3. Signed x=7, y=-3 -> p=24'hFFFFEB. Zero operand (x=0, y=12'h5A5) -> p=0.
4. Backpressure: hold out_ready=0 for 20 cycles after completion. p and out_valid stay stable and in_ready=0. Then assert out_ready together with in_valid (x=3, y=5): the new op is accepted that cycle, and p=15 appears 8 cycles later.
5. Assert rst during BUSY at cnt=3: outputs immediately go to reset values, with no spurious out_valid. The next op x=100, y=-100 (signed) completes correctly as p=24'hFFD8F0.
6. Random regression of 10k ops, mixed mode, random handshake stalls, WIDTH in {4, 12, 16}: compare p against the reference product modulo 2^(2*WIDTH).

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and Booth recoding helpers for the radix-4 multiplier family.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic signed [2:0] DIG_ZERO = 3'sd0;
  localparam logic signed [2:0] DIG_P1   = 3'sd1;
  localparam logic signed [2:0] DIG_P2   = 3'sd2;
  localparam logic signed [2:0] DIG_M1   = -3'sd1;
  localparam logic signed [2:0] DIG_M2   = -3'sd2;

  // group is {y[2k+1], y[2k], y[2k-1]}
  function automatic logic signed [2:0] booth_digit(input logic [2:0] group);
    case (group)
      3'b001, 3'b010: booth_digit = DIG_P1;
      3'b011:         booth_digit = DIG_P2;
      3'b100:         booth_digit = DIG_M2;
      3'b101, 3'b110: booth_digit = DIG_M1;
      default:        booth_digit = DIG_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Radix-4 Booth partial product: digit(group) * x_ext, exact in WIDTH+3 signed bits.
module booth_r4_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic        [2:0]       group,
  input  logic signed [WIDTH+1:0] x_ext,
  output logic signed [WIDTH+2:0] pp
);

  logic signed [WIDTH+2:0] x_sx;
  logic signed [2:0]       digit;

  always_comb begin
    x_sx  = {x_ext[WIDTH+1], x_ext};
    digit = booth_digit(group);
    case (digit)
      DIG_P1:  pp = x_sx;
      DIG_P2:  pp = x_sx <<< 1;
      DIG_M1:  pp = -x_sx;
      DIG_M2:  pp = -(x_sx <<< 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   BUSY  | accumulating one Booth digit per edge
//   DONE  | product held on p until out_ready
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int N  = (WIDTH + 2) / 2;
  localparam int CW = $clog2(N);
  localparam int XW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 4;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_chk
    $error("booth_mult_seq: WIDTH must be even and >= 4");
  end

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [XW-1:0]  x_q, x_d;
  logic [XW-1:0]         y_q, y_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [2*WIDTH-1:0]    p_q, p_d;
  logic                  out_valid_q, out_valid_d;

  logic [XW:0]           y_pad;
  logic [2:0]            group;
  logic signed [XW:0]    pp;
  logic signed [AW-1:0]  pp_ext;
  logic signed [AW-1:0]  acc_next;
  logic                  accept;

  // y_pad supplies the implicit y[-1] = 0 below bit 0
  assign y_pad    = {y_q, 1'b0};
  assign group    = y_pad[{cnt_q, 1'b0} +: 3];
  assign pp_ext   = {{(AW-XW-1){pp[XW]}}, pp};
  assign acc_next = acc_q + (pp_ext <<< {cnt_q, 1'b0});

  booth_r4_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
    .group (group),
    .x_ext (x_q),
    .pp    (pp)
  );

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == BUSY);
  assign out_valid = out_valid_q;
  assign p         = p_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    acc_d       = acc_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: ;
      BUSY: begin
        acc_d = acc_next;
        if (cnt_q == CW'(N - 1)) begin
          p_d         = acc_next[2*WIDTH-1:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // accept only happens in IDLE or a consumed DONE, so it overrides the above
    if (accept) begin
      x_d         = {{2{is_signed & x[WIDTH-1]}}, x};
      y_d         = {{2{is_signed & y[WIDTH-1]}}, y};
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      state_d     = BUSY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and short random checks of booth_mult_seq at WIDTH=12.
module tb_booth_mult_seq;

  localparam int W = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          is_signed = 1'b0;
  logic [W-1:0]  x = '0;
  logic [W-1:0]  y = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] p;
  logic          busy;

  int n_vec  = 0;
  int n_miss = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    return (2*W)'(sa * sb);
  endfunction

  // Present operands from IDLE; returns at the first negedge after the accept edge
  task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid  = 1'b1;
    is_signed = s;
    x         = a;
    y         = b;
    @(negedge clk);
    in_valid  = 1'b0;
    x         = W'($urandom);
    y         = W'($urandom);
    is_signed = ~s;
  endtask

  task automatic wait_done(input string tag, input logic [2*W-1:0] exp, input bit chk_lat);
    int cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    if (chk_lat) chk({tag, " latency"}, 64'(cyc), 64'd8);
    chk({tag, " p"}, 64'(p), 64'(exp));
  endtask

  task automatic consume(input string tag, input logic [2*W-1:0] exp, input int stall);
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " drop"}, 64'(out_valid), 64'd0);
    chk({tag, " keep p"}, 64'(p), 64'(exp));
  endtask

  task automatic run(input string tag, input logic s, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [2*W-1:0] exp);
    start_op(s, a, b);
    wait_done(tag, exp, 1'b1);
    consume(tag, exp, 0);
  endtask

  initial begin
    logic seen;
    logic s;
    logic [W-1:0] a, b;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset p", 64'(p), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);

    run("s min*min", 1'b1, 12'h800, 12'h800, 24'h400000);
    run("u fff*fff", 1'b0, 12'hFFF, 12'hFFF, 24'hFFE001);
    run("s -1*-1",   1'b1, 12'hFFF, 12'hFFF, 24'h000001);
    run("s 7*-3",    1'b1, 12'h007, 12'hFFD, 24'hFFFFEB);
    run("u 0*5a5",   1'b0, 12'h000, 12'h5A5, 24'h000000);
    run("s min*max", 1'b1, 12'h800, 12'h7FF, 24'hC00800);
    run("u 800*800", 1'b0, 12'h800, 12'h800, 24'h400000);
    run("s fff*1",   1'b1, 12'hFFF, 12'h001, 24'hFFFFFF);
    run("u fff*1",   1'b0, 12'hFFF, 12'h001, 24'h000FFF);

    // Backpressure: result held while a new request waits
    start_op(1'b0, 12'h800, 12'h002);
    wait_done("bp first", 24'h001000, 1'b1);
    in_valid  = 1'b1;
    is_signed = 1'b0;
    x         = 12'd3;
    y         = 12'd5;
    repeat (20) begin
      @(negedge clk);
      chk("bp hold p", 64'(p), 64'h1000);
      chk("bp hold valid", 64'(out_valid), 64'd1);
      chk("bp in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp accept ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = 12'hABC;
    y         = 12'h123;
    chk("bp valid drop", 64'(out_valid), 64'd0);
    chk("bp busy", 64'(busy), 64'd1);
    wait_done("bp second", 24'd15, 1'b1);
    consume("bp second", 24'd15, 0);

    // Reset while BUSY at cnt=3
    start_op(1'b0, 12'd5, 12'd5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst p", 64'(p), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("rst no valid", 64'(seen), 64'd0);
    run("s 100*-100", 1'b1, 12'd100, 12'hF9C, 24'hFFD8F0);

    for (int i = 0; i < 150; i++) begin
      s = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      start_op(s, a, b);
      wait_done("rand", ref_mul(s, a, b), 1'b0);
      consume("rand", ref_mul(s, a, b), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
